// File: rtl/mips_multicycle_datapath.sv
// Multi-cycle MIPS datapath subset: one instruction per handshake, private regfile and data memory.
// Latency: accept-to-done 3 cycles (R/imm/SW), 4 (LW), 2 (illegal); instr_ready only in IDLE, busy-time valids are dropped.
module mips_multicycle_datapath #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instrword,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              done,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int MEM_AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42;
    localparam logic [5:0] FN_SLTU = 6'd43;

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLTU} alu_op_t;

    state_t state, state_nxt;

    logic [31:0]       ir;
    logic [DATA_W-1:0] a, b, imm, aluout, mdr;
    logic [DATA_W-1:0] rf  [32];
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [5:0] op, func;
    logic [4:0] rs, rt, rd, dest;
    assign op   = ir[31:26];
    assign rs   = ir[25:21];
    assign rt   = ir[20:16];
    assign rd   = ir[15:11];
    assign func = ir[5:0];

    logic    is_r, is_lw, is_sw, is_zext, instr_illegal;
    alu_op_t alu_op;
    assign is_r    = (op == OP_RTYPE);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_zext = (op == OP_ANDI) || (op == OP_ORI);
    assign dest    = is_r ? rd : rt;

    always_comb begin
        alu_op        = ALU_ADD;
        instr_illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    default: instr_illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
            OP_ANDI: alu_op = ALU_AND;
            OP_ORI:  alu_op = ALU_OR;
            default: instr_illegal = 1'b1;
        endcase
    end

    logic [DATA_W-1:0] opnd_b, alu_res;
    assign opnd_b = is_r ? b : imm;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = a + opnd_b;
            ALU_SUB:  alu_res = a - opnd_b;
            ALU_AND:  alu_res = a & opnd_b;
            ALU_OR:   alu_res = a | opnd_b;
            ALU_NOR:  alu_res = ~(a | opnd_b);
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(opnd_b))};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (a < opnd_b)};
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC: begin
                if (instr_illegal)       state_nxt = IDLE;
                else if (is_lw || is_sw) state_nxt = MEM;
                else                     state_nxt = WB;
            end
            MEM:     state_nxt = is_lw ? WB : IDLE;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign instr_ready = (state == IDLE);
    assign illegal     = (state == EXEC) && instr_illegal;
    assign done        = illegal || (state == WB) || ((state == MEM) && is_sw);

    // ADDI/LW/SW sign-extend their 16-bit field; ANDI/ORI zero-extend it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            imm    <= '0;
            aluout <= '0;
            mdr    <= '0;
        end else begin
            if (state == IDLE && instr_valid) ir <= instrword;
            if (state == DECODE) begin
                a   <= rf[rs];
                b   <= rf[rt];
                imm <= {{(DATA_W-16){ir[15] & ~is_zext}}, ir[15:0]};
            end
            if (state == EXEC) aluout <= alu_res;
            if (state == MEM && is_lw) mdr <= mem[aluout[MEM_AW-1:0]];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (state == WB && dest != 5'd0) begin
            rf[dest] <= is_lw ? mdr : aluout;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (state == MEM && is_sw) begin
            mem[aluout[MEM_AW-1:0]] <= b;
        end
    end

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Directed bench for mips_multicycle_datapath: hand-encoded instructions, register results via debug port.
module tb_mips_multicycle_datapath;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instrword = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready, done, illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int n_cmp = 0;
    int n_bad = 0;

    mips_multicycle_datapath #(.DATA_W(32), .MEM_DEPTH(128)) dut (
        .clock       (clock),
        .reset       (reset),
        .instrword   (instrword),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .done        (done),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        rtype = {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] imm);
        itype = {op[5:0], rs[4:0], rt[4:0], imm};
    endfunction

    task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
        dbg_addr = idx[4:0];
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Issues one instruction and measures accept-edge-to-done latency.
    task automatic run_instr(input string tag, input logic [31:0] iw, input int exp_lat, input logic exp_ill);
        int  lat;
        bit  seen;
        @(negedge clock);
        chk({tag, "_rdy"}, {31'd0, instr_ready}, 32'd1);
        instrword   = iw;
        instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (lat < 8 && !seen) begin
            @(negedge clock);
            lat++;
            if (lat == 1) chk({tag, "_busy"}, {31'd0, instr_ready}, 32'd0);
            if (done) begin
                seen = 1'b1;
                chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        @(negedge clock);
        chk({tag, "_post"}, {30'd0, done, instr_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_done",  {30'd0, done, illegal}, 32'd0);
        chk_reg("rst_r1", 1, 32'd0);

        run_instr("addi1", itype(8, 0, 1, 16'd5), 3, 1'b0);
        run_instr("addi2", itype(8, 0, 2, 16'hFFFD), 3, 1'b0);
        chk_reg("r1", 1, 32'd5);
        chk_reg("r2", 2, 32'hFFFF_FFFD);

        run_instr("add",  rtype(1, 2, 3, 32), 3, 1'b0);
        run_instr("sub",  rtype(2, 1, 4, 34), 3, 1'b0);
        run_instr("slt",  rtype(2, 1, 5, 42), 3, 1'b0);
        run_instr("sltu", rtype(2, 1, 6, 43), 3, 1'b0);
        run_instr("and",  rtype(1, 2, 10, 36), 3, 1'b0);
        run_instr("or",   rtype(1, 2, 11, 37), 3, 1'b0);
        run_instr("nor",  rtype(1, 2, 12, 39), 3, 1'b0);
        chk_reg("r3", 3, 32'd2);
        chk_reg("r4", 4, 32'hFFFF_FFF8);
        chk_reg("r5", 5, 32'd1);
        chk_reg("r6", 6, 32'd0);
        chk_reg("r10", 10, 32'd5);
        chk_reg("r11", 11, 32'hFFFF_FFFD);
        chk_reg("r12", 12, 32'd2);

        run_instr("sw",  itype(43, 0, 1, 16'd130), 3, 1'b0);
        run_instr("lw",  itype(35, 0, 7, 16'd2), 4, 1'b0);
        chk_reg("r7", 7, 32'd5);

        run_instr("addi0", itype(8, 0, 0, 16'd7), 3, 1'b0);
        run_instr("ori",   itype(13, 0, 8, 16'h8000), 3, 1'b0);
        run_instr("andi",  itype(12, 8, 9, 16'hFFFF), 3, 1'b0);
        chk_reg("r0", 0, 32'd0);
        chk_reg("r8", 8, 32'h0000_8000);
        chk_reg("r9", 9, 32'h0000_8000);

        run_instr("j",    itype(2, 1, 1, 16'd5), 2, 1'b1);
        run_instr("fn18", rtype(1, 2, 3, 24), 2, 1'b1);
        chk_reg("ill_r1", 1, 32'd5);
        chk_reg("ill_r3", 3, 32'd2);
        chk_reg("ill_r8", 8, 32'h0000_8000);

        // Abort SW $1,0($0) during its MEM cycle.
        @(negedge clock);
        instrword   = itype(43, 0, 1, 16'd0);
        instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_mem_done", {31'd0, done}, 32'd1);
        reset = 1'b0;
        #3 reset = 1'b1;
        @(negedge clock);
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk_reg("abort_r1", 1, 32'd0);
        chk_reg("abort_r7", 7, 32'd0);
        run_instr("abort_lw0", itype(35, 0, 13, 16'd0), 4, 1'b0);
        run_instr("abort_lw2", itype(35, 0, 14, 16'd2), 4, 1'b0);
        chk_reg("abort_mem0", 13, 32'd0);
        chk_reg("abort_mem2", 14, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_datapath.md
Name: mips_multicycle_datapath

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS datapath. It executes one instruction word per valid/ready handshake through an internal control FSM (DECODE/EXEC/MEM/WB), with a private register file and data memory. It adds immediate ALU ops, signed/unsigned set-less-than, an illegal-instruction flag, and a debug register read port. It sits behind the future PC/instruction-fetch block; there is no PC or branch logic here.

Parameters:
DATA_W, 32, datapath/register/memory word width (>=16; immediates extend to DATA_W)
MEM_DEPTH, 128, data memory depth in words (power of 2)
MEM_AW, $clog2(MEM_DEPTH), word-address width into data memory (derived, not overridden)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
instrword  in  32  MIPS instruction, sampled on handshake
instr_valid  in  1  instruction present
instr_ready  out  1  high only in IDLE
done  out  1  one-cycle pulse, instruction retired
illegal  out  1  one-cycle pulse with done, unsupported opcode/func
dbg_addr  in  5  debug register index
dbg_data  out  DATA_W  combinational register-file read of dbg_addr ($0 reads 0)

Behaviour:
- Reset (reset=0, async): state=IDLE; all 32 registers and all MEM_DEPTH memory words=0; done=0, illegal=0, instr_ready=1 after release. Reset mid-instruction aborts it; no register or memory write occurs.
- Handshake: accept on the rising edge with instr_valid & instr_ready; instrword latched into IR. instr_valid while busy is ignored (not queued).
- FSM: IDLE -> DECODE -> EXEC -> {WB | MEM} ; MEM(LW) -> WB ; MEM(SW) -> IDLE ; WB -> IDLE ; illegal: EXEC -> IDLE.
- DECODE: A<=R[rs], B<=R[rt], IMM<=extended imm[15:0].
- EXEC: ALUOUT<=A op (B or IMM). done/illegal assert during EXEC only for illegal instructions.
- MEM: LW: MDR<=mem[ALUOUT[MEM_AW-1:0]]; SW: mem[ALUOUT[MEM_AW-1:0]]<=B at the closing edge, done=1 during this cycle.
- WB: R[dest]<=ALUOUT (R-type/imm) or MDR (LW) at the closing edge; done=1 during this cycle. dest=rd for R-type, rt otherwise. Writes to $0 are discarded.
- Latency, accept edge to done cycle: R-type/imm 3 cycles, SW 3, LW 4, illegal 2. instr_ready returns the cycle after done.
- Supported, opcode 0 by func: 32 ADD, 34 SUB, 36 AND, 37 OR, 39 NOR, 42 SLT (signed), 43 SLTU (unsigned). Opcode 8 ADDI (sign-ext), 12 ANDI (zero-ext), 13 ORI (zero-ext), 35 LW, 43 SW (both sign-ext offset). Anything else is illegal: no state change.
- Arithmetic: modulo 2^DATA_W with no overflow trap. SLT/SLTU produce 1 or 0, zero-extended to DATA_W.
- Memory addressing: word-addressed, low MEM_AW bits of ALUOUT, upper bits ignored (wraps).
- Register-file read in DECODE sees writes committed by the previous instruction. There is no same-cycle read/write hazard, because only one instruction is in flight.
- dbg_data is purely combinational and has no side effects.

Test Plan:
- Reset, then ADDI $1,$0,5; ADDI $2,$0,-3 -> dbg $1=5, $2=0xFFFFFFFD; done 3 cycles after each accept; instr_ready low while busy.
- ADD $3,$1,$2; SUB $4,$2,$1; SLT $5,$2,$1; SLTU $6,$2,$1 -> $3=2, $4=0xFFFFFFF8, $5=1, $6=0.
- SW $1,130($0); LW $7,2($0) -> $7=5 via address wrap (130 mod 128=2); LW done 4 cycles after accept, SW done 3 cycles after accept.
- ADDI $0,$0,7; ORI $8,$0,0x8000 -> $0 reads 0; $8=0x00008000 (zero-extended); ANDI $9,$8,0xFFFF -> $9=0x8000.
- Opcode 2 (J) and R-type func 0x18 -> illegal=done=1, 2 cycles after accept; all registers unchanged.
- Assert reset low during the MEM cycle of SW $1,0($0) -> mem[0] and all registers read 0 after release; instr_ready=1.
